// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST engine.
package bist_pkg;

  // Engine sequencing states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } bist_state_e;

  // Default pattern generator taps (x^8 + x^6 + x^5 + x^4 + 1 style mask)
  localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;

  // Default signature register feedback mask
  localparam logic [7:0] DEF_MISR_POLY = 8'h1D;

endpackage : bist_pkg

// File: rtl/bist_misr.sv
// Multiple-input signature register with clear and enable.
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned   W    = 8,
  parameter logic [W-1:0]  POLY = W'(DEF_MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_sig,
  output logic [W-1:0] o_sig_next_c
);

  logic [W-1:0] r_sig;
  logic [W-1:0] w_shift;

  assign w_shift = {r_sig[W-2:0], i_bit} ^ (r_sig[W-1] ? POLY : '0);

  // Next signature: clear wins over absorb, otherwise hold
  always_comb begin
    o_sig_next_c = r_sig;
    if (i_clr) begin
      o_sig_next_c = '0;
    end else if (i_en) begin
      o_sig_next_c = w_shift;
    end
  end

  // Signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= '0;
    end else begin
      r_sig <= o_sig_next_c;
    end
  end

  assign o_sig = r_sig;

endmodule : bist_misr

// File: rtl/param_bist_engine.sv
// Scan-based BIST engine: LFSR patterns shift into a 2N-bit chain, an N x N
// multiplier captures into the chain, and the unloaded responses are
// compacted by a MISR and compared against a golden signature.
module param_bist_engine
  import bist_pkg::*;
#(
  parameter int unsigned         N         = 4,
  parameter int unsigned         LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
  parameter logic [LFSR_W-1:0]   LFSR_SEED = LFSR_W'(8'h01),
  parameter logic [2*N-1:0]      MISR_POLY = (2*N)'(DEF_MISR_POLY),
  parameter int unsigned         PATTERNS  = 15,
  parameter logic [2*N-1:0]      GOLDEN    = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*N-1:0] signature,
  output logic           scan_in,
  output logic           scan_out
);

  localparam int unsigned CW     = 2 * N;
  localparam int unsigned SCNT_W = $clog2(CW) + 1;
  localparam int unsigned PCNT_W = $clog2(PATTERNS + 1) + 1;

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  localparam logic [LFSR_W-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  bist_state_e         r_state;
  bist_state_e         w_state_next;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [LFSR_W-1:0]   w_lfsr_next;
  logic [LFSR_W-1:0]   w_lfsr_step;
  logic [CW-1:0]       r_chain;
  logic [CW-1:0]       w_chain_next;
  logic [CW-1:0]       w_prod;
  logic [SCNT_W-1:0]   r_scnt;
  logic [SCNT_W-1:0]   w_scnt_next;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [PCNT_W-1:0]   w_pcnt_next;
  logic [PCNT_W-1:0]   w_pcnt_inc;
  logic                w_misr_clr;
  logic                w_misr_en;
  logic                w_last_shift;
  logic [CW-1:0]       w_sig;
  logic [CW-1:0]       w_sig_next;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;

  assign w_lfsr_step  = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
  assign w_prod       = CW'(r_chain[CW-1:N]) * CW'(r_chain[N-1:0]);
  assign w_pcnt_inc   = r_pcnt + PCNT_W'(1);
  assign w_last_shift = (r_scnt == SCNT_W'(CW - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_next = r_state;
    w_lfsr_next  = r_lfsr;
    w_chain_next = r_chain;
    w_scnt_next  = r_scnt;
    w_pcnt_next  = r_pcnt;
    w_misr_clr   = 1'b0;
    w_misr_en    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_lfsr_next  = SEED_EFF;
          w_chain_next = '0;
          w_scnt_next  = '0;
          w_pcnt_next  = '0;
          w_misr_clr   = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_chain_next = {r_chain[CW-2:0], r_lfsr[LFSR_W-1]};
        w_lfsr_next  = w_lfsr_step;
        // The first pattern's shift-out carries only the cleared chain
        w_misr_en    = (r_pcnt != '0);
        if (w_last_shift) begin
          w_scnt_next  = '0;
          w_state_next = CAPTURE;
        end else begin
          w_scnt_next  = r_scnt + SCNT_W'(1);
        end
      end
      CAPTURE: begin
        w_chain_next = w_prod;
        w_pcnt_next  = w_pcnt_inc;
        w_state_next = (w_pcnt_inc == PCNT_W'(PATTERNS)) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        w_chain_next = {r_chain[CW-2:0], 1'b0};
        w_misr_en    = 1'b1;
        if (w_last_shift) begin
          w_scnt_next  = '0;
          w_state_next = DONE;
        end else begin
          w_scnt_next  = r_scnt + SCNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= SEED_EFF;
      r_chain <= '0;
      r_scnt  <= '0;
      r_pcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_chain <= w_chain_next;
      r_scnt  <= w_scnt_next;
      r_pcnt  <= w_pcnt_next;
      r_busy  <= (w_state_next == SHIFT) || (w_state_next == CAPTURE) ||
                 (w_state_next == UNLOAD);
      r_done  <= (w_state_next == DONE);
      r_pass  <= (w_state_next == DONE) && (w_sig_next == GOLDEN);
    end
  end

  bist_misr #(
    .W    (CW),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clr        (w_misr_clr),
    .i_en         (w_misr_en),
    .i_bit        (r_chain[CW-1]),
    .o_sig        (w_sig),
    .o_sig_next_c (w_sig_next)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = w_sig;
  assign scan_in   = r_lfsr[LFSR_W-1];
  assign scan_out  = r_chain[CW-1];

endmodule : param_bist_engine

// File: tb/tb_param_bist_engine.sv
// Scoreboard bench for param_bist_engine across several parameter sets.
module tb_param_bist_engine;

  localparam int NI = 5;

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    int         cycles;
  } exp_t;

  logic          clk = 1'b0;
  logic [NI-1:0] st;
  logic [NI-1:0] rn;
  logic [NI-1:0] bz;
  logic [NI-1:0] dn;
  logic [NI-1:0] ps;
  logic [NI-1:0] si;
  logic [NI-1:0] so;
  logic [7:0]    sg [NI];

  exp_t sb_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1/2: seed 23 single pattern, 3: three patterns, 4: zero seed
  param_bist_engine u_def (
    .clk(clk), .rst_n(rn[0]), .start(st[0]), .busy(bz[0]), .done(dn[0]),
    .pass(ps[0]), .signature(sg[0]), .scan_in(si[0]), .scan_out(so[0]));

  param_bist_engine #(.LFSR_SEED(8'h23), .PATTERNS(1), .GOLDEN(8'h06)) u_p1g (
    .clk(clk), .rst_n(rn[1]), .start(st[1]), .busy(bz[1]), .done(dn[1]),
    .pass(ps[1]), .signature(sg[1]), .scan_in(si[1]), .scan_out(so[1]));

  param_bist_engine #(.LFSR_SEED(8'h23), .PATTERNS(1), .GOLDEN(8'h00)) u_p1z (
    .clk(clk), .rst_n(rn[2]), .start(st[2]), .busy(bz[2]), .done(dn[2]),
    .pass(ps[2]), .signature(sg[2]), .scan_in(si[2]), .scan_out(so[2]));

  param_bist_engine #(.PATTERNS(3)) u_p3 (
    .clk(clk), .rst_n(rn[3]), .start(st[3]), .busy(bz[3]), .done(dn[3]),
    .pass(ps[3]), .signature(sg[3]), .scan_in(si[3]), .scan_out(so[3]));

  param_bist_engine #(.LFSR_SEED(8'h00), .PATTERNS(3)) u_s0 (
    .clk(clk), .rst_n(rn[4]), .start(st[4]), .busy(bz[4]), .done(dn[4]),
    .pass(ps[4]), .signature(sg[4]), .scan_in(si[4]), .scan_out(so[4]));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-accurate reference for N=4, LFSR_W=8, default taps and poly
  function automatic logic [7:0] model_sig(input logic [7:0] seed, input int npat);
    logic [7:0] lfsr;
    logic [7:0] chain;
    logic [7:0] misr;
    logic       sob;
    lfsr  = (seed == 8'h00) ? 8'h01 : seed;
    chain = 8'h00;
    misr  = 8'h00;
    for (int p = 0; p < npat; p++) begin
      for (int i = 0; i < 8; i++) begin
        sob   = chain[7];
        chain = {chain[6:0], lfsr[7]};
        lfsr  = {lfsr[6:0], ^(lfsr & 8'hB8)};
        if (p != 0) misr = {misr[6:0], sob} ^ (misr[7] ? 8'h1D : 8'h00);
      end
      chain = {4'h0, chain[7:4]} * {4'h0, chain[3:0]};
    end
    for (int i = 0; i < 8; i++) begin
      sob   = chain[7];
      chain = {chain[6:0], 1'b0};
      misr  = {misr[6:0], sob} ^ (misr[7] ? 8'h1D : 8'h00);
    end
    return misr;
  endfunction

  task automatic push_exp(input logic [7:0] sig, input logic [7:0] golden, input int npat);
    exp_t e;
    e.sig    = sig;
    e.pass   = (sig == golden);
    e.cycles = npat * 9 + 8;
    sb_q.push_back(e);
  endtask

  // Pulse start, measure busy, optionally pulse start again mid-run,
  // then pop the scoreboard and compare the finished run.
  task automatic run(input int idx, input int npat, input int glitch_at,
                     input string tag, output logic [7:0] first8, output int maxz);
    exp_t e;
    int   c;
    int   z;
    logic [7:0] sig_done;
    @(negedge clk); st[idx] = 1'b1;
    @(negedge clk); st[idx] = 1'b0;
    c = 0; z = 0; maxz = 0; first8 = 8'h00;
    while (bz[idx] === 1'b1 && c < 2000) begin
      st[idx] = (c == glitch_at);
      if (c < npat * 9 && (c % 9) != 8) begin
        z    = (si[idx] === 1'b0) ? z + 1 : 0;
        maxz = (z > maxz) ? z : maxz;
      end
      if (c < 8) first8 = {first8[6:0], si[idx]};
      c++;
      @(negedge clk);
    end
    st[idx] = 1'b0;
    check({tag, "_timeout"}, 32'(c >= 2000), 32'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_busy_cycles"}, 32'(c), 32'(e.cycles));
      check({tag, "_done"}, 32'(dn[idx]), 32'd1);
      check({tag, "_sig"}, 32'(sg[idx]), 32'(e.sig));
      check({tag, "_pass"}, 32'(ps[idx]), 32'(e.pass));
      sig_done = sg[idx];
      repeat (4) @(negedge clk);
      check({tag, "_done_hold"}, 32'(dn[idx]), 32'd1);
      check({tag, "_sig_hold"}, 32'(sg[idx]), 32'(sig_done));
      check({tag, "_pass_hold"}, 32'(ps[idx]), 32'(e.pass));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f8;
    logic [7:0] ref_def;
    int         mz;
    st = '0;
    rn = '0;
    ref_def = model_sig(8'h01, 15);
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_busy", 32'(bz[0]), 32'd0);
    check("rst_done", 32'(dn[0]), 32'd0);
    check("rst_pass", 32'(ps[0]), 32'd0);
    check("rst_sig", 32'(sg[0]), 32'd0);
    check("rst_scan_out", 32'(so[0]), 32'd0);
    check("rst_scan_in", 32'(si[0]), 32'd0);
    rn = '1;
    repeat (2) @(negedge clk);
    check("idle_no_start_busy", 32'(bz), 32'd0);

    // Seed 23, one pattern: chain loads a=2 b=3, product 06 unloads to signature 06
    push_exp(8'h06, 8'h06, 1);
    run(1, 1, -1, "p1_gold06", f8, mz);
    check("p1_chain_load", 32'(f8), 32'h23);
    push_exp(8'h06, 8'h00, 1);
    run(2, 1, -1, "p1_gold00", f8, mz);

    // Three patterns: busy for exactly 35 cycles
    push_exp(model_sig(8'h01, 3), 8'h00, 3);
    run(3, 3, -1, "p3", f8, mz);

    // Zero seed substitutes 1; no all-zero run of LFSR_W bits
    push_exp(model_sig(8'h01, 3), 8'h00, 3);
    run(4, 3, -1, "seed0", f8, mz);
    check("seed0_first8", 32'(f8), 32'h01);
    check("seed0_no_stuck", 32'(mz < 8), 32'd1);

    // Default run, then restart from DONE, then start pulsed during SHIFT
    push_exp(ref_def, 8'h00, 15);
    run(0, 15, -1, "def_run1", f8, mz);
    push_exp(ref_def, 8'h00, 15);
    run(0, 15, -1, "def_run2", f8, mz);
    push_exp(ref_def, 8'h00, 15);
    run(0, 15, 3, "def_glitch", f8, mz);

    // Reset asserted during UNLOAD
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (138) @(negedge clk);
    check("unl_busy_before_rst", 32'(bz[0]), 32'd1);
    rn[0] = 1'b0;
    #1;
    check("unl_rst_busy", 32'(bz[0]), 32'd0);
    check("unl_rst_done", 32'(dn[0]), 32'd0);
    check("unl_rst_pass", 32'(ps[0]), 32'd0);
    check("unl_rst_sig", 32'(sg[0]), 32'd0);
    check("unl_rst_scan_out", 32'(so[0]), 32'd0);
    check("unl_rst_scan_in", 32'(si[0]), 32'd0);
    @(negedge clk); rn[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("unl_idle_busy", 32'(bz[0]), 32'd0);
    check("unl_idle_done", 32'(dn[0]), 32'd0);
    push_exp(ref_def, 8'h00, 15);
    run(0, 15, -1, "def_after_rst", f8, mz);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_param_bist_engine
